uart_tx_fifo: RTL and testbench

Serial transmitter with a small input FIFO, placed directly upstream of the team's UART receiver. It accepts bytes over a valid/ready write port, buffers them, and serialises each byte onto `tx` at one bit per `enable` tick. Frame format exactly matches what the receiver expects:
- start bit 0
- 8 data bits, LSB first
- even-parity bit (XOR of the 8 data bits)
- stop bit 1

---
 rtl/uart_tx_fifo.sv | 183 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small byte FIFO: start, 8 data bits LSB first, even parity, stop, optional idle gap.
// Optional build macro UART_TX_PARITY_INJECT_EN adds force_par_err to corrupt the parity of the next frame.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int IDLE_GAP   = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [7:0]                    wr_data,
  input  logic                          wr_valid,
`ifdef UART_TX_PARITY_INJECT_EN
  input  logic                          force_par_err,
`endif
  output logic                          wr_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_GAP} state_t;

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

  state_t         state_q, state_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic [2:0]     bitcnt_q, bitcnt_d;
  logic [3:0]     gapcnt_q, gapcnt_d;
  logic           tx_q, tx_d;
  logic           busy_q, busy_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [7:0]     mem_q [FIFO_DEPTH];
  logic           push_s, launch_s, empty_s, par_flip_s;

  assign wr_ready   = !rst && (count_q < CW'(FIFO_DEPTH));
  assign empty_s    = (count_q == '0);
  assign push_s     = wr_valid && wr_ready;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;

`ifdef UART_TX_PARITY_INJECT_EN
  logic inj_q, inj_d;
  assign par_flip_s = inj_q;

  // Sticky request, consumed when the parity bit is launched.
  always_comb begin
    inj_d = force_par_err | (inj_q & !(enable && (state_q == S_DATA) && (bitcnt_q == 3'd7)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inj_q <= 1'b0;
    end else begin
      inj_q <= inj_d;
    end
  end
`else
  assign par_flip_s = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    par_d    = par_q;
    bitcnt_d = bitcnt_q;
    gapcnt_d = gapcnt_q;
    tx_d     = tx_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    launch_s = 1'b0;
    if (enable) begin
      case (state_q)
        S_IDLE: begin
          if (!empty_s) launch_s = 1'b1;
          else          tx_d = 1'b1;
        end
        S_START: begin
          tx_d     = shift_q[0];
          shift_d  = shift_q >> 1;
          bitcnt_d = 3'd0;
          state_d  = S_DATA;
        end
        S_DATA: begin
          if (bitcnt_q == 3'd7) begin
            tx_d    = par_q ^ par_flip_s;
            state_d = S_PARITY;
          end else begin
            tx_d     = shift_q[0];
            shift_d  = shift_q >> 1;
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end
        S_PARITY: begin
          tx_d    = 1'b1;
          state_d = S_STOP;
        end
        S_STOP: begin
          if (IDLE_GAP > 0) begin
            gapcnt_d = 4'(IDLE_GAP);
            state_d  = S_GAP;
          end else if (!empty_s) begin
            launch_s = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_GAP: begin
          gapcnt_d = gapcnt_q - 4'd1;
          if (gapcnt_q == 4'd1) begin
            if (!empty_s) launch_s = 1'b1;
            else          state_d = S_IDLE;
          end else begin
            state_d = S_GAP;
          end
        end
        default: begin
          tx_d    = 1'b1;
          state_d = S_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    // Frame launch pops the head; a same-cycle push only becomes visible next cycle.
    if (launch_s) begin
      shift_d  = mem_q[rd_ptr_q];
      par_d    = even_parity(mem_q[rd_ptr_q]);
      tx_d     = 1'b0;
      state_d  = S_START;
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_s) wr_ptr_d = wr_ptr_q + AW'(1);
    else        wr_ptr_d = wr_ptr_q;
    case ({push_s, launch_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      shift_q  <= 8'h00;
      par_q    <= 1'b0;
      bitcnt_q <= 3'd0;
      gapcnt_q <= 4'd0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      bitcnt_q <= bitcnt_d;
      gapcnt_q <= gapcnt_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_s) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised scoreboard bench for uart_tx_fifo: two instances (IDLE_GAP 0 and 2) share stimulus;
// a monitor decodes tx bit periods and compares them against queued bytes and framing rules.
module tb_uart_tx_fifo;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, enable = 1'b0, wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       force_par_err = 1'b0;
  logic [1:0] wr_ready, tx, busy;
  logic [2:0] cnt [2];

  uart_tx_fifo #(.FIFO_DEPTH(4), .IDLE_GAP(0)) u0 (
    .clk(clk), .rst(rst), .enable(enable), .wr_data(wr_data), .wr_valid(wr_valid),
`ifdef UART_TX_PARITY_INJECT_EN
    .force_par_err(force_par_err),
`endif
    .wr_ready(wr_ready[0]), .tx(tx[0]), .busy(busy[0]), .fifo_count(cnt[0]));

  uart_tx_fifo #(.FIFO_DEPTH(4), .IDLE_GAP(2)) u2 (
    .clk(clk), .rst(rst), .enable(enable), .wr_data(wr_data), .wr_valid(wr_valid),
`ifdef UART_TX_PARITY_INJECT_EN
    .force_par_err(force_par_err),
`endif
    .wr_ready(wr_ready[1]), .tx(tx[1]), .busy(busy[1]), .fifo_count(cnt[1]));

  int checks = 0;
  int failures = 0;

  // Reference state per instance: bytes waiting in the FIFO, and the frame being decoded.
  logic [7:0] q [2][$];
  int         inframe [2];
  int         bitidx [2];
  int         run [2];
  logic [7:0] cur [2];
  logic       inj [2];
  logic       last_tx [2];

  int en_div = 4;
  int ecnt = 0;
  bit en_hold = 1'b0;

  function automatic int gap_of(input int i);
    return (i == 0) ? 0 : 2;
  endfunction

  task automatic check(input string nm, input int i, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t got=%0h expected=%0h", nm, i, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (en_hold) begin
      enable = 1'b0;
    end else begin
      enable = ((ecnt % en_div) == 0);
      ecnt++;
    end
  end

  // Monitor: samples inputs at the edge, outputs 1 time unit later, then updates the model.
  always @(posedge clk) begin
    logic r, en, v, f;
    logic [7:0] d;
    int qn [2];
    r = rst; en = enable; v = wr_valid; d = wr_data; f = force_par_err;
    for (int i = 0; i < 2; i++) qn[i] = q[i].size();
    #1;
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        q[i].delete();
        inframe[i] = 0; run[i] = 99; inj[i] = 1'b0;
        check("reset_tx", i, 8'(tx[i]), 8'd1);
        check("reset_busy", i, 8'(busy[i]), 8'd0);
      end else begin
        if (en) begin
          if (inframe[i] == 0) begin
            bit exp_start;
            exp_start = (qn[i] > 0) && (run[i] >= gap_of(i));
            check("idle_line", i, 8'(tx[i]), exp_start ? 8'd0 : 8'd1);
            check("idle_busy", i, 8'(busy[i]), (exp_start || run[i] < gap_of(i)) ? 8'd1 : 8'd0);
            if (tx[i] == 1'b0) begin
              inframe[i] = 1; bitidx[i] = 0;
              cur[i] = (q[i].size() > 0) ? q[i].pop_front() : 8'h00;
            end else if (run[i] < 99) begin
              run[i]++;
            end
          end else begin
            logic e;
            bitidx[i]++;
            if (bitidx[i] <= 8)       e = cur[i][bitidx[i]-1];
            else if (bitidx[i] == 9)  e = (^cur[i]) ^ inj[i];
            else                      e = 1'b1;
            check(bitidx[i] <= 8 ? "data_bit" : (bitidx[i] == 9 ? "parity_bit" : "stop_bit"),
                  i, 8'(tx[i]), 8'(e));
            check("frame_busy", i, 8'(busy[i]), 8'd1);
            if (bitidx[i] == 9) inj[i] = 1'b0;
            if (bitidx[i] == 10) begin inframe[i] = 0; run[i] = 0; end
          end
        end else begin
          check("tx_hold", i, 8'(tx[i]), 8'(last_tx[i]));
        end
        if (v && qn[i] < 4) q[i].push_back(d);
`ifdef UART_TX_PARITY_INJECT_EN
        if (f) inj[i] = 1'b1;
`else
        if (f) inj[i] = 1'b0;
`endif
      end
      check("fifo_count", i, 8'(cnt[i]), 8'(q[i].size()));
      check("wr_ready", i, 8'(wr_ready[i]), 8'(!rst && q[i].size() < 4));
      last_tx[i] = tx[i];
    end
  end

  task automatic write_byte(input logic [7:0] b);
    wr_data = b; wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    // Single frames with enable every 4 clocks.
    write_byte(8'hA5); idle(70);
    write_byte(8'h07); idle(70);
    // Fill with enable held low; the fifth write must be refused.
    en_hold = 1'b1;
    for (int b = 1; b <= 5; b++) write_byte(8'(b));
    idle(4);
    en_hold = 1'b0;
    idle(4 * 4 * 14 + 40);
    // Reset in the middle of a frame with bytes queued.
    write_byte(8'h5A); write_byte(8'h11); write_byte(8'h22);
    idle(22);
    rst = 1'b1; idle(1); rst = 1'b0;
    idle(80);
    // Back-to-back pair: exercises the idle gap on the second instance.
    write_byte(8'h11); write_byte(8'h22);
    idle(150);
`ifdef UART_TX_PARITY_INJECT_EN
    force_par_err = 1'b1; idle(1); force_par_err = 1'b0;
    write_byte(8'hA5); write_byte(8'h3C);
    idle(140);
`endif
    // Randomised traffic with varying enable rate and occasional reset.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 199) == 0) en_div = $urandom_range(1, 5);
      rst = ($urandom_range(0, 999) == 0);
      wr_data = 8'($urandom);
      wr_valid = ($urandom_range(0, 5) == 0);
      @(negedge clk);
    end
    wr_valid = 1'b0; rst = 1'b0;
    guard = 0;
    while ((q[0].size() != 0 || q[1].size() != 0 || inframe[0] != 0 || inframe[1] != 0 ||
            busy != 2'b00) && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 5000) begin
      failures++;
      $display("FAIL drain_timeout got=%0d cycles expected<5000", guard);
    end
    idle(10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
